// File: rtl/trend_pkg.sv
// Shared types and constants for the trend_sched scheduler and its evaluator.
package trend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_COMMIT
  } state_t;

  localparam int WIN_W = 4;
  localparam int SUM_W = 4;
  localparam int TH_W  = 5;

  localparam logic [SUM_W-1:0] WT3 = 4'd8;
  localparam logic [SUM_W-1:0] WT2 = 4'd4;
  localparam logic [SUM_W-1:0] WT1 = 4'd2;
  localparam logic [SUM_W-1:0] WT0 = 4'd1;

  // Max total is 15, so the 4-bit sum never wraps.
  function automatic logic [SUM_W-1:0] weighted_sum(input logic [WIN_W-1:0] w);
    weighted_sum = (w[3] ? WT3 : '0) + (w[2] ? WT2 : '0)
                 + (w[1] ? WT1 : '0) + (w[0] ? WT0 : '0);
  endfunction

endpackage

// File: rtl/trend_sched_if.sv
// Request/grant and update-broadcast bundle between bit sources and trend_sched.
interface trend_sched_if
  import trend_pkg::*;
#(
  parameter int NCH = 4
);
  localparam int CH_W = $clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_bit;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   trend;
  logic             upd_valid;
  logic [CH_W-1:0]  upd_ch;
  logic             upd_trend;
  logic [SUM_W-1:0] upd_sum;

  modport master (
    output req_valid, req_bit,
    input  req_ready, trend, upd_valid, upd_ch, upd_trend, upd_sum
  );

  modport slave (
    input  req_valid, req_bit,
    output req_ready, trend, upd_valid, upd_ch, upd_trend, upd_sum
  );
endinterface

// File: rtl/trend_eval.sv
// Shared combinational evaluator: shifts a sample into a window, weights it and
// applies set/clear hysteresis against the current trend.
module trend_eval
  import trend_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  input  logic             sample,
  input  logic             cur_trend,
  input  logic [TH_W-1:0]  hi,
  input  logic [TH_W-1:0]  lo,
  output logic [WIN_W-1:0] win_new,
  output logic [SUM_W-1:0] sum,
  output logic             trend_next
);

  assign win_new = {win[WIN_W-2:0], sample};
  assign sum     = weighted_sum(win_new);

  always_comb begin
    // NOTE: default first so every path assigns trend_next and no latch is inferred.
    trend_next = cur_trend;
    if (TH_W'(sum) >= hi) begin
      trend_next = 1'b1;
    end else if (TH_W'(sum) < lo) begin
      trend_next = 1'b0;
    end
  end

endmodule

// File: rtl/trend_sched.sv
// Round-robin scheduler time-sharing one trend_eval across NCH bit streams.
// Optional runtime threshold port enabled by defining TREND_SCHED_CFG_EN.
module trend_sched
  import trend_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int TH_HI = 8,
  parameter int TH_LO = 4
) (
  input logic           clk,
  input logic           reset,
  trend_sched_if.slave  bus
`ifdef TREND_SCHED_CFG_EN
  ,
  input logic             cfg_we,
  input logic [TH_W-1:0]  cfg_hi,
  input logic [TH_W-1:0]  cfg_lo
`endif
);

  localparam int CH_W = $clog2(NCH);

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  cur_ch;
  logic             cur_bit;
  logic [WIN_W-1:0] win_q [NCH];
  logic [NCH-1:0]   trend_q;
  logic [WIN_W-1:0] eval_win;

  logic             upd_valid_q;
  logic [CH_W-1:0]  upd_ch_q;
  logic             upd_trend_q;
  logic [SUM_W-1:0] upd_sum_q;

  logic [TH_W-1:0]  hi;
  logic [TH_W-1:0]  lo;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx;
  int               scan_idx;

  logic [WIN_W-1:0] win_new;
  logic [SUM_W-1:0] sum;
  logic             trend_next;

`ifdef TREND_SCHED_CFG_EN
  // Inconsistent pairs (lo above hi) are dropped so hysteresis stays well-formed.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= TH_W'(TH_HI);
      lo <= TH_W'(TH_LO);
    end else if (cfg_we && (cfg_lo <= cfg_hi)) begin
      hi <= cfg_hi;
      lo <= cfg_lo;
    end
  end
`else
  assign hi = TH_W'(TH_HI);
  assign lo = TH_W'(TH_LO);
`endif

  // First requester at or after rr_ptr, wrapping at NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
      if (!grant_found && bus.req_valid[CH_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(scan_idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == ST_IDLE && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  trend_eval u_eval (
    .win        (win_q[cur_ch]),
    .sample     (cur_bit),
    .cur_trend  (trend_q[cur_ch]),
    .hi         (hi),
    .lo         (lo),
    .win_new    (win_new),
    .sum        (sum),
    .trend_next (trend_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_ch      <= '0;
      cur_bit     <= 1'b0;
      eval_win    <= '0;
      trend_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      upd_trend_q <= 1'b0;
      upd_sum_q   <= '0;
      // NOTE: the context array is reset because a channel's first sums must start from an empty window.
      for (int c = 0; c < NCH; c++) win_q[c] <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      upd_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            cur_ch  <= grant_idx;
            cur_bit <= bus.req_bit[grant_idx];
            state   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          eval_win    <= win_new;
          upd_valid_q <= 1'b1;
          upd_ch_q    <= cur_ch;
          upd_trend_q <= trend_next;
          upd_sum_q   <= sum;
          state       <= ST_COMMIT;
        end
        ST_COMMIT: begin
          win_q[cur_ch]   <= eval_win;
          trend_q[cur_ch] <= upd_trend_q;
          rr_ptr          <= (cur_ch == CH_W'(NCH - 1)) ? '0 : cur_ch + 1'b1;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.trend     = trend_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_ch    = upd_ch_q;
  assign bus.upd_trend = upd_trend_q;
  assign bus.upd_sum   = upd_sum_q;

endmodule

// File: tb/tb_trend_sched.sv
// Scoreboard bench for trend_sched: a sample-history model predicts grants and
// update broadcasts; a separate monitor pops and compares them.
module tb_trend_sched;
  import trend_pkg::*;

  localparam int NCH   = 4;
  localparam int TH_HI = 8;
  localparam int TH_LO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  trend_sched_if #(.NCH(NCH)) bus ();

`ifdef TREND_SCHED_CFG_EN
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_hi = '0;
  logic [4:0] cfg_lo = '0;
`endif

  trend_sched #(.NCH(NCH), .TH_HI(TH_HI), .TH_LO(TH_LO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef TREND_SCHED_CFG_EN
    ,
    .cfg_we (cfg_we),
    .cfg_hi (cfg_hi),
    .cfg_lo (cfg_lo)
`endif
  );

  typedef struct {
    int ch;
    int trend;
    int sum;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: per-channel sample history, newest last.
  bit hist[NCH][$];
  int m_trend[NCH];
  int m_rr = 0;
  int busy = 0;
  int m_hi = TH_HI;
  int m_lo = TH_LO;

  // Sample of age a (0 = newest) carries weight 2**a; only four samples count.
  function automatic int model_sum(input int ch);
    int s, n;
    s = 0;
    n = hist[ch].size();
    for (int a = 0; a < 4 && a < n; a++) s += int'(hist[ch][n-1-a]) << a;
    return s;
  endfunction

  always @(negedge clk) begin : grant_model
    logic [NCH-1:0] exp_rdy;
    int g, s, j;
    exp_t e;
    if (reset) begin
      sb.delete();
      for (int c = 0; c < NCH; c++) begin
        hist[c].delete();
        m_trend[c] = 0;
      end
      m_rr = 0;
      busy = 0;
      m_hi = TH_HI;
      m_lo = TH_LO;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (busy == 0) begin
        for (int k = 0; k < NCH; k++) begin
          j = (m_rr + k) % NCH;
          if (g < 0 && bus.req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        hist[g].push_back(bus.req_bit[g]);
        if (hist[g].size() > 4) void'(hist[g].pop_front());
        s = model_sum(g);
        if (s >= m_hi) m_trend[g] = 1;
        else if (s < m_lo) m_trend[g] = 0;
        e.ch = g; e.trend = m_trend[g]; e.sum = s; e.due = cyc + 2;
        sb.push_back(e);
        m_rr = (g + 1) % NCH;
        busy = 2;
      end else if (busy > 0) begin
        busy--;
      end
    end
  end

  logic [NCH-1:0] vis = '0;
  int pend_at = -1;
  int pend_ch = 0;
  int pend_val = 0;

  always @(negedge clk) begin : upd_monitor
    exp_t e;
    if (reset) begin
      vis = '0;
      pend_at = -1;
    end else begin
      if (pend_at == cyc) begin
        vis[pend_ch] = pend_val[0];
        pend_at = -1;
      end
      if (bus.upd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("upd_spurious", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("upd_ch",    32'(bus.upd_ch),    e.ch);
          check("upd_trend", 32'(bus.upd_trend), e.trend);
          check("upd_sum",   32'(bus.upd_sum),   e.sum);
          check("upd_cycle", cyc,                e.due);
          pend_ch = e.ch; pend_val = e.trend; pend_at = cyc + 1;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("upd_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      check("trend", 32'(bus.trend), 32'(vis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready[ch] !== 1'b1 && n < 40);
    check("grant_seen", 32'(bus.req_ready[ch]), 32'd1);
  endtask

  task automatic send(input int ch, input bit b);
    tick();
    bus.req_valid[ch] = 1'b1;
    bus.req_bit[ch]   = b;
    wait_grant(ch);
    tick();
    bus.req_valid[ch] = 1'b0;
  endtask

  // Directed sample whose update values are fixed constants.
  task automatic send_chk(input int ch, input bit b, input int exp_sum, input int exp_trend);
    send(ch, b);
    @(negedge clk);
    @(negedge clk);
    check("plan_valid", 32'(bus.upd_valid), 32'd1);
    check("plan_sum",   32'(bus.upd_sum),   exp_sum);
    check("plan_trend", 32'(bus.upd_trend), exp_trend);
  endtask

  task automatic run_random(input int ncyc, input bit all_on);
    logic [NCH-1:0] rdy_s;
    repeat (ncyc) begin
      @(negedge clk);
      rdy_s = bus.req_ready;
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (rdy_s[c]) begin
          bus.req_valid[c] = all_on ? 1'b1 : 1'($urandom % 2);
          bus.req_bit[c]   = 1'($urandom % 2);
        end else if (bus.req_valid[c]) begin
          if (!all_on && ($urandom % 16) == 0) bus.req_valid[c] = 1'b0;
        end else if (all_on || ($urandom % 3) == 0) begin
          bus.req_valid[c] = 1'b1;
          bus.req_bit[c]   = 1'($urandom % 2);
        end
      end
    end
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
  endtask

`ifdef TREND_SCHED_CFG_EN
  task automatic cfg_write(input int hi, input int lo);
    tick();
    cfg_we = 1'b1;
    cfg_hi = 5'(hi);
    cfg_lo = 5'(lo);
    tick();
    cfg_we = 1'b0;
    if (lo <= hi) begin
      m_hi = hi;
      m_lo = lo;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_bit   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("rst_upd_ch",    32'(bus.upd_ch),    32'd0);
    check("rst_upd_trend", 32'(bus.upd_trend), 32'd0);
    check("rst_upd_sum",   32'(bus.upd_sum),   32'd0);
    check("rst_trend",     32'(bus.trend),     32'd0);

    // Channel 0 ramp through the window.
    send_chk(0, 1, 1, 0);
    send_chk(0, 1, 3, 0);
    send_chk(0, 0, 6, 0);
    send_chk(0, 0, 12, 1);
    send_chk(0, 0, 8, 1);
    send_chk(0, 0, 0, 0);

    // Hysteresis on channel 1.
    send_chk(1, 1, 1, 0);
    send_chk(1, 0, 2, 0);
    send_chk(1, 1, 5, 0);
    send_chk(1, 1, 11, 1);
    send_chk(1, 0, 6, 1);
    send_chk(1, 0, 12, 1);
    repeat (2) tick();
    check("ch1_trend_set", 32'(bus.trend[1]), 32'd1);

    // Reset during EVAL of a channel-1 sample.
    tick();
    bus.req_valid[1] = 1'b1;
    bus.req_bit[1]   = 1'b1;
    wait_grant(1);
    tick();
    bus.req_valid[1] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid[0] = 1'b1; bus.req_bit[0] = 1'b0;
    bus.req_valid[2] = 1'b1; bus.req_bit[2] = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 32'(bus.req_ready), 32'h1);
    check("post_rst_trend", 32'(bus.trend),     32'd0);
    check("post_rst_upd",   32'(bus.upd_valid), 32'd0);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_grant(2);
    tick();
    bus.req_valid[2] = 1'b0;
    repeat (4) tick();

    // Channel 2 withdraws its request while the evaluator is busy.
    tick();
    bus.req_valid[0] = 1'b1;
    bus.req_bit[0]   = 1'b1;
    wait_grant(0);
    tick();
    bus.req_valid[0] = 1'b0;
    bus.req_valid[2] = 1'b1;
    bus.req_bit[2]   = 1'b1;
    tick();
    bus.req_valid[2] = 1'b0;
    repeat (4) tick();
    send_chk(2, 0, 0, 0);
    repeat (3) tick();

    // All channels continuously valid, then free-running random traffic.
    run_random(40, 1'b1);
    run_random(400, 1'b0);

`ifdef TREND_SCHED_CFG_EN
    cfg_write(12, 2);
    repeat (4) send(0, 0);
    repeat (3) tick();
    send_chk(0, 1, 1, 0);
    send_chk(0, 1, 3, 0);
    send_chk(0, 0, 6, 0);
    send_chk(0, 0, 12, 1);
    cfg_write(3, 5);
    send_chk(0, 0, 8, 1);
    send_chk(0, 0, 0, 0);
    send_chk(0, 1, 1, 0);
    send_chk(0, 1, 3, 0);
    repeat (3) tick();
`endif

    repeat (6) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
